// File: rtl/ravan_arb_pkg.sv
// rtl/ravan_arb_pkg.sv - state encoding, counter widths and saturating helper for the core arbiter
package ravan_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Core latency down-counter width (CORE_LAT up to 15)
  localparam int CNT_W = 4;

  // Statistics counter width and its saturation value
  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

  // Increment that sticks at STAT_MAX instead of wrapping
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/ravan_rr_pick.sv
// rtl/ravan_rr_pick.sv - combinational round-robin winner select starting at ptr
module ravan_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDW-1:0]   gnt_idx,
  output logic             any
);

  int best_d;
  int d;

  // Pick the valid requester with the smallest circular distance from ptr
  always_comb begin
    best_d  = N_REQ;
    d       = 0;
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i + N_REQ - int'(ptr)) % N_REQ;
      if (req_valid[i] && (d < best_d)) begin
        best_d  = d;
        gnt_idx = IDW'(i);
      end
    end
  end

  // Expand the winning index to a one-hot grant, empty when nobody asks
  always_comb begin
    any        = |req_valid;
    gnt_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_onehot[i] = any && (gnt_idx == IDW'(i));
    end
  end

endmodule

// File: rtl/ravan_core_arbiter.sv
// rtl/ravan_core_arbiter.sv - round-robin sharing of one RAVAN_TOP core; RAVAN_ARB_STATS_EN adds grant/error counters
module ravan_core_arbiter
  import ravan_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CORE_LAT = 3,
  parameter int IDW      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*64-1:0]  req_data,
  input  logic [N_REQ*512-1:0] req_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  output logic                 core_sel,
  output logic [63:0]          core_data_in,
  output logic [511:0]         core_key,
  input  logic [63:0]          core_data_out,
  input  logic                 core_sha_error,
  output logic                 busy
`ifdef RAVAN_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] grant_cnt,
  output logic [STAT_W-1:0]       err_cnt
`endif
);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] gnt_onehot;
  logic [IDW-1:0]   gnt_idx;
  logic             any;
  logic             accept;
  logic             capture;
  logic [63:0]      win_data;
  logic [511:0]     win_key;

  ravan_rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req_valid  (req_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign accept  = (state == IDLE) && any;
  assign capture = (state == BUSY) && (cnt == CNT_W'(1));
  assign ptr_nxt = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
  assign busy    = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grant; only IDLE ever offers a grant
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = gnt_onehot;
        if (any) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Route the winner's data and key toward the core input registers
  always_comb begin
    win_data = '0;
    win_key  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_onehot[i]) begin
        win_data = req_data[i*64 +: 64];
        win_key  = req_key[i*512 +: 512];
      end
    end
  end

  // Core drive, latency count, result capture and response hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= '0;
      cnt          <= '0;
      core_sel     <= 1'b0;
      core_data_in <= '0;
      core_key     <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= '0;
      rsp_err      <= 1'b0;
    end else if (accept) begin
      core_data_in <= win_data;
      core_key     <= win_key;
      rsp_id       <= gnt_idx;
      ptr          <= ptr_nxt;
      cnt          <= CNT_W'(CORE_LAT);
      core_sel     <= 1'b1;
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
      if (capture) begin
        rsp_data  <= core_data_out;
        rsp_err   <= core_sha_error;
        rsp_valid <= 1'b1;
        core_sel  <= 1'b0;
      end
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef RAVAN_ARB_STATS_EN
  logic [STAT_W-1:0] stat_gnt [N_REQ];
  logic [STAT_W-1:0] stat_err;

  // Per-requester accept counters, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) stat_gnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept && gnt_onehot[i]) stat_gnt[i] <= sat_inc(stat_gnt[i]);
      end
    end
  end

  // Count captures that carried a core error, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_err <= '0;
    end else if (capture && core_sha_error) begin
      stat_err <= sat_inc(stat_err);
    end
  end

  // Flatten the grant counters onto the output bus
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) grant_cnt[i*STAT_W +: STAT_W] = stat_gnt[i];
  end

  assign err_cnt = stat_err;
`endif

endmodule

// File: tb/tb_ravan_core_arbiter.sv
// tb/tb_ravan_core_arbiter.sv - directed scoreboard bench for ravan_core_arbiter
module tb_ravan_core_arbiter;

  localparam int N_REQ    = 4;
  localparam int CORE_LAT = 3;
  localparam int IDW      = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*64-1:0]  req_data;
  logic [N_REQ*512-1:0] req_key;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [63:0]          rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_err;
  logic                 core_sel;
  logic [63:0]          core_data_in;
  logic [511:0]         core_key;
  logic [63:0]          core_data_out;
  logic                 core_sha_error;
  logic                 busy;
`ifdef RAVAN_ARB_STATS_EN
  logic [N_REQ*16-1:0]  grant_cnt;
  logic [15:0]          err_cnt;
`endif

  ravan_core_arbiter #(
    .N_REQ    (N_REQ),
    .CORE_LAT (CORE_LAT),
    .IDW      (IDW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .req_key        (req_key),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_id         (rsp_id),
    .rsp_err        (rsp_err),
    .core_sel       (core_sel),
    .core_data_in   (core_data_in),
    .core_key       (core_key),
    .core_data_out  (core_data_out),
    .core_sha_error (core_sha_error),
    .busy           (busy)
`ifdef RAVAN_ARB_STATS_EN
    ,
    .grant_cnt      (grant_cnt),
    .err_cnt        (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: result depends on inputs and on how long core_sel has been high
  logic [3:0] core_phase = 4'd0;
  logic       err_inject;
  always @(posedge clk) core_phase <= core_sel ? core_phase + 4'd1 : 4'd0;
  assign core_data_out  = (core_data_in ^ core_key[63:0]) + {60'd0, core_phase};
  assign core_sha_error = err_inject;

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    data;
    logic           err;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  logic [63:0]  d_tab [N_REQ];
  logic [511:0] k_tab [N_REQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected response: core sampled after CORE_LAT-1 increments of its phase
  function automatic logic [63:0] exp_data(input int i);
    logic [511:0] k;
    k = k_tab[i];
    return (d_tab[i] ^ k[63:0]) + 64'(CORE_LAT - 1);
  endfunction

  task automatic push_exp(input int i, input logic e);
    exp_t x;
    x.id   = IDW'(i);
    x.data = exp_data(i);
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait for a grant, follow the op through the core, compare the response
  task automatic observe_op(input string tag, input int exp_idx, output longint t_acc);
    int           n;
    int           sel_hi;
    logic [3:0]   exp_rdy;
    exp_t         e;
    #1;
    n = 0;
    while (!(|req_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    exp_rdy = 4'b0001 << exp_idx;
    chk({tag, "_grant"}, 64'(req_ready), 64'(exp_rdy));
    t_acc = cyc + 1;
    @(negedge clk);
    chk({tag, "_ready_drop"}, 64'(req_ready), 64'd0);
    n = 0;
    sel_hi = 0;
    while (!rsp_valid && n < 40) begin
      if (core_sel) sel_hi++;
      @(negedge clk);
      n++;
    end
    if (core_sel) sel_hi++;
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_sel_cycles"}, 64'(sel_hi), 64'(CORE_LAT));
    chk({tag, "_latency"}, 64'(cyc - t_acc), 64'(CORE_LAT));
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(e.id));
      chk({tag, "_rsp_data"}, rsp_data, e.data);
      chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(e.err));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t;
    longint t_prev;
    int     order [6];
    int     unstable;
    int     n;
    logic   saw_rsp;
    logic [63:0] h_data;
    logic [IDW-1:0] h_id;
    logic   h_err;

    order = '{0, 1, 3, 0, 1, 3};
    for (int i = 0; i < N_REQ; i++) begin
      d_tab[i] = {32'hA5A5_0000 + 32'(i), 32'h1357_9BDF ^ 32'(i * 32'h1111_1111)};
      k_tab[i] = {16{32'hC0DE_0000 + 32'(i * 7 + 3)}};
      req_data[i*64 +: 64]   = d_tab[i];
      req_key[i*512 +: 512]  = k_tab[i];
    end
    d_tab[2] = 64'h0123_4567_89AB_CDEF;
    req_data[2*64 +: 64] = d_tab[2];

    rst        = 1'b0;
    req_valid  = '0;
    rsp_ready  = 1'b1;
    err_inject = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_core_sel", 64'(core_sel), 64'd0);
    chk("rst_core_data_in", core_data_in, 64'd0);
    chk("rst_core_key", 64'(|core_key), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single request from requester 2
    push_exp(2, 1'b0);
    req_valid = 4'b0100;
    observe_op("t1", 2, t);
    req_valid = '0;
    @(negedge clk);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // Simultaneous requests from ptr 0, continuous, rsp_ready high
    do_reset();
    for (int k = 0; k < 6; k++) push_exp(order[k], 1'b0);
    req_valid = 4'b1011;
    t_prev = 0;
    for (int k = 0; k < 6; k++) begin
      observe_op($sformatf("t2_op%0d", k), order[k], t);
      if (k > 0) chk($sformatf("t2_spacing%0d", k), 64'(t - t_prev), 64'(CORE_LAT + 2));
      t_prev = t;
    end
    req_valid = '0;
    @(negedge clk);

    // Back-pressure: hold response for 10 cycles
    rsp_ready = 1'b0;
    push_exp(0, 1'b0);
    req_valid = 4'b0001;
    observe_op("t3", 0, t);
    h_data = rsp_data;
    h_id   = rsp_id;
    h_err  = rsp_err;
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== h_data || rsp_id !== h_id || rsp_err !== h_err || req_ready !== '0)
        unstable++;
    end
    chk("t3_hold_stable", 64'(unstable), 64'd0);
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("t3_idle_busy", 64'(busy), 64'd0);
    chk("t3_idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // Error propagation, then a clean op
    err_inject = 1'b1;
    push_exp(1, 1'b1);
    req_valid = 4'b0010;
    observe_op("t4_err", 1, t);
    err_inject = 1'b0;
    push_exp(1, 1'b0);
    observe_op("t4_ok", 1, t);
    req_valid = '0;
`ifdef RAVAN_ARB_STATS_EN
    chk("t4_err_cnt", 64'(err_cnt), 64'd1);
`endif
    @(negedge clk);

    // Reset while busy with cnt==2
    req_valid = 4'b0100;
    #1;
    n = 0;
    while (!(|req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_grant", 64'(req_ready), 64'd4);
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_before", 64'(busy), 64'd1);
    req_valid = '0;
    rst = 1'b0;
    #1;
    chk("t5_core_sel", 64'(core_sel), 64'd0);
    chk("t5_core_data_in", core_data_in, 64'd0);
    chk("t5_core_key", 64'(|core_key), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rsp_data", rsp_data, 64'd0);
    chk("t5_rsp_id", 64'(rsp_id), 64'd0);
    chk("t5_rsp_err", 64'(rsp_err), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_rsp = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      saw_rsp = saw_rsp | rsp_valid;
    end
    chk("t5_no_rsp", 64'(saw_rsp), 64'd0);
    push_exp(1, 1'b0);
    req_valid = 4'b1010;
    observe_op("t5_after", 1, t);
    req_valid = '0;
    @(negedge clk);

`ifdef RAVAN_ARB_STATS_EN
    // Grant counter saturation for requester 0
    dut.stat_gnt[0] = 16'hFFFE;
    push_exp(0, 1'b0);
    push_exp(0, 1'b0);
    req_valid = 4'b0001;
    observe_op("t6_a", 0, t);
    observe_op("t6_b", 0, t);
    req_valid = '0;
    @(negedge clk);
    chk("t6_grant_sat", 64'(grant_cnt[15:0]), 64'h0000_0000_0000_FFFF);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
